// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, funct codes,
// ALU operations and the main FSM state type.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } statetype;

endpackage

// File: rtl/multicycle_controller_if.sv
// Datapath-facing bundle of the multicycle controller: instruction fields and
// status in, per-cycle enables and mux selects out.
interface multicycle_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memready;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic       pcen;
  logic [2:0] alucontrol;

  modport master (
    output op, funct, zero, memready,
    input  iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, pcen, alucontrol
  );

  modport slave (
    input  op, funct, zero, memready,
    output iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, pcen, alucontrol
  );
endinterface

// File: rtl/aludec.sv
// ALU decoder: maps the main FSM's aluop and the R-type funct field to the ALU
// operation; anything unrecognised falls back to add.
module aludec
  import mips_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: alucontrol = ALU_ADD;
          FUNCT_SUB: alucontrol = ALU_SUB;
          FUNCT_AND: alucontrol = ALU_AND;
          FUNCT_OR:  alucontrol = ALU_OR;
          FUNCT_SLT: alucontrol = ALU_SLT;
          default:   alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_mainfsm.sv
// Main Moore FSM of the multicycle controller: state register, instruction
// sequencing and per-state datapath control decode.
module mc_mainfsm
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       memready,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       branch,
  output logic       pcwrite
);

  statetype state, next_state, decode_state;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

  // During reset the outputs show the FETCH decode with every write enable held
  // off, so nothing architectural changes whatever state the register holds.
  always_comb begin
    next_state = state;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    aluop      = ALUOP_ADD;
    branch     = 1'b0;
    pcwrite    = 1'b0;
    decode_state = reset ? FETCH : state;

    case (decode_state)
      FETCH: begin
        alusrcb = 2'b01;
        if (memready) begin
          irwrite    = 1'b1;
          pcwrite    = 1'b1;
          next_state = DECODE;
        end
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE:     next_state = RTYPEEX;
          OP_BEQ:       next_state = BEQEX;
          OP_ADDI:      next_state = ADDIEX;
          OP_J:         next_state = JEX;
          default:      next_state = FETCH;
        endcase
      end
      MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        next_state = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord = 1'b1;
        if (memready) next_state = MEMWB;
      end
      MEMWB: begin
        memtoreg   = 1'b1;
        regwrite   = 1'b1;
        next_state = FETCH;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        if (memready) next_state = FETCH;
      end
      RTYPEEX: begin
        alusrca    = 1'b1;
        aluop      = ALUOP_FUNCT;
        next_state = RTYPEWB;
      end
      RTYPEWB: begin
        regdst     = 1'b1;
        regwrite   = 1'b1;
        next_state = FETCH;
      end
      BEQEX: begin
        alusrca    = 1'b1;
        aluop      = ALUOP_SUB;
        pcsrc      = 2'b01;
        branch     = 1'b1;
        next_state = FETCH;
      end
      ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        next_state = ADDIWB;
      end
      ADDIWB: begin
        regwrite   = 1'b1;
        next_state = FETCH;
      end
      JEX: begin
        pcsrc      = 2'b10;
        pcwrite    = 1'b1;
        next_state = FETCH;
      end
      default: next_state = FETCH;
    endcase

    if (reset) begin
      memwrite = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
      pcwrite  = 1'b0;
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control unit: main sequencing FSM plus ALU decoder, with the
// PC enable formed from unconditional writes and taken branches.
module multicycle_controller
  import mips_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  multicycle_controller_if.slave  bus
);

  logic [1:0] aluop;
  logic       branch;
  logic       pcwrite;

  mc_mainfsm u_mainfsm (
    .clk      (clk),
    .reset    (reset),
    .op       (bus.op),
    .memready (bus.memready),
    .iord     (bus.iord),
    .memwrite (bus.memwrite),
    .irwrite  (bus.irwrite),
    .regdst   (bus.regdst),
    .memtoreg (bus.memtoreg),
    .regwrite (bus.regwrite),
    .alusrca  (bus.alusrca),
    .alusrcb  (bus.alusrcb),
    .pcsrc    (bus.pcsrc),
    .aluop    (aluop),
    .branch   (branch),
    .pcwrite  (pcwrite)
  );

  aludec u_aludec (
    .aluop      (aluop),
    .funct      (bus.funct),
    .alucontrol (bus.alucontrol)
  );

  assign bus.pcen = pcwrite | (branch & bus.zero);

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control unit for the multicycle MIPS datapath: a Moore state machine that sequences fetch, decode, execute, memory and writeback over several clocks per instruction, sharing one ALU and one unified instruction/data memory. It decodes `op`/`funct` into per-cycle datapath enables and mux selects. It waits on a memory-ready handshake so the same datapath works with single-cycle or wait-stated memory. It replaces the single-cycle controller when the multicycle datapath is selected.

## Interface
Parameters: none.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `op` in 6: opcode from instruction register.
- `funct` in 6: function field from instruction register.
- `zero` in 1: ALU zero flag.
- `memready` in 1: memory access completes this cycle.
- `iord` out 1: memory address select (0 = PC, 1 = ALUOut).
- `memwrite` out 1: memory write enable.
- `irwrite` out 1: instruction register load.
- `regdst` out 1: write-register select (1 = rd, 0 = rt).
- `memtoreg` out 1: writeback select (1 = Data, 0 = ALUOut).
- `regwrite` out 1: register file write enable.
- `alusrca` out 1: ALU A select (0 = PC, 1 = A).
- `alusrcb` out 2: ALU B select (00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2).
- `pcsrc` out 2: next PC select (00 = ALUResult, 01 = ALUOut, 10 = jump target).
- `pcen` out 1: PC load.
- `alucontrol` out 3: ALU operation.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX.
- Unlisted outputs are 0 and `aluop` is 00.
  - FETCH: `alusrcb`=01. When `memready`=1, also `irwrite`=1 and `pcwrite`=1.
  - DECODE: `alusrcb`=11.
  - MEMADR: `alusrca`=1, `alusrcb`=10.
  - MEMRD: `iord`=1.
  - MEMWB: `memtoreg`=1, `regwrite`=1.
  - MEMWR: `iord`=1, `memwrite`=1.
  - RTYPEEX: `alusrca`=1, `aluop`=10.
  - RTYPEWB: `regdst`=1, `regwrite`=1.
  - BEQEX: `alusrca`=1, `aluop`=01, `pcsrc`=01, `branch`=1.
  - ADDIEX: `alusrca`=1, `alusrcb`=10.
  - ADDIWB: `regwrite`=1.
  - JEX: `pcsrc`=10, `pcwrite`=1.
- `pcen = pcwrite | (branch & zero)`.
- Transitions:
  - FETCH→DECODE only when `memready`=1; otherwise FETCH is held.
  - DECODE dispatches on `op`:
    - 100011 (lw) or 101011 (sw) → MEMADR.
    - 000000 (R-type) → RTYPEEX.
    - 000100 (beq) → BEQEX.
    - 001000 (addi) → ADDIEX.
    - 000010 (j) → JEX.
    - Any other opcode → FETCH; no architectural write occurs.
  - MEMADR → MEMRD for lw, MEMWR for sw.
  - MEMRD → MEMWB when `memready`=1; otherwise held with `iord`=1.
  - MEMWR → FETCH when `memready`=1; otherwise held with `memwrite`=1 for every wait cycle.
  - RTYPEEX→RTYPEWB, ADDIEX→ADDIWB.
  - MEMWB, RTYPEWB, BEQEX, ADDIWB and JEX all → FETCH.
- ALU decode (`aluop` → `alucontrol`):
  - `aluop` 00 → 010 (add).
  - `aluop` 01 → 110 (sub).
  - `aluop` 10 decodes `funct`: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111.
  - Undefined `funct` → 010.
  - `aluop` 11 → 010.
- Outputs depend combinationally on state, plus `zero` (for `pcen`) and `memready` (FETCH only). There are no output registers.

## Timing
- Reset: `reset`=1 at a rising edge puts state in FETCH, from any state including mid-instruction.
- While `reset`=1, `memwrite`, `irwrite`, `regwrite` and `pcen` are forced to 0. The other outputs show FETCH decode.
- Cycles per instruction with `memready` held at 1:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
  - Illegal opcode 2.
- Each cycle `memready`=0 in FETCH, MEMRD or MEMWR adds one cycle. `irwrite` and `pcen` pulse exactly once per fetch, in the completing cycle.
- `memready`=1 outside FETCH, MEMRD or MEMWR is ignored.
- `zero` is sampled only through `pcen` in BEQEX.

## Structure
- Package `mips_pkg`:
  - Opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J).
  - Funct constants.
  - `statetype` enum, 4-bit encoding.
  - ALU control constants.
- Sub-module `mc_mainfsm` holds the state register, next-state logic and the Moore output decode, including `aluop`, `branch` and `pcwrite`.
- The existing `aludec` is instantiated for `alucontrol`. It is updated so that undefined `funct` yields 010.
- The top level contains only the two instances and the `pcen` gate.

## Test plan
- lw, `memready`=1: state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB. `iord`=1 in MEMRD. `regwrite`=1, `memtoreg`=1 only in cycle 5.
- sw with `memready` low for 2 cycles in MEMWR: `memwrite`=1 for exactly 3 cycles, then FETCH. `regwrite` is never asserted.
- R-type `funct`=101010: `alucontrol`=111 in RTYPEEX. `regdst`=1, `regwrite`=1 in RTYPEWB.
- beq: with `zero`=1, `pcen`=1, `pcsrc`=01 in BEQEX. With `zero`=0, `pcen`=0. The next state is FETCH in both cases.
- FETCH with `memready` 0,0,1: `irwrite`/`pcen` high only in the third cycle, then DECODE. Opcode 111111 in DECODE → FETCH with all write enables 0.
- `reset` asserted in MEMWR with `memready`=0: `memwrite`=0 during reset, FETCH on the next cycle. Then j: `pcsrc`=10, `pcen`=1 in JEX.
